// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU accumulator sequencer.
//                Provides ALU opcode encodings, the sequencer FSM state type
//                and the bit positions of the ALU error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU opcode encodings
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_MOD    = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_XNOR   = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_NOR    = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_NAND   = 4'd10;
  localparam logic [3:0] OP_NOT    = 4'd11;
  localparam logic [3:0] OP_ZERO0  = 4'd12;
  localparam logic [3:0] OP_ZERO1  = 4'd13;
  localparam logic [3:0] OP_PRESET = 4'd14;
  localparam logic [3:0] OP_CLR    = 4'd15;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // ALU error flag bit positions
  localparam int ERR_OVF  = 0;
  localparam int ERR_DIVZ = 1;

endpackage
`default_nettype wire

// File: rtl/alu_acc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_sequencer_if
//  Description : Command / response handshake bundle of the ALU accumulator
//                sequencer.
//                master : issues commands, consumes responses
//                slave  : the sequencer
//  Signals     : cmd_valid/cmd_ready/cmd_op/cmd_load/cmd_operand,
//                rsp_valid/rsp_ready/rsp_result/rsp_error
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_acc_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic              cmd_load;
  logic [DATA_W-1:0] cmd_operand;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [1:0]        rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_error
  );
endinterface
`default_nettype wire

// File: rtl/alu_acc_sequencer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_fsm
//  Description : Control FSM of the ALU accumulator sequencer.
//                IDLE -> EXEC on command handshake, EXEC -> WB always,
//                WB -> IDLE when the response is consumed.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                i_cmd_valid         - command present
//                i_rsp_ready         - response consumer ready
//                o_cmd_ready         - command may be accepted (IDLE only)
//                o_rsp_valid         - response present (WB only)
//                o_accept            - command handshake this cycle
//                o_exec              - ALU result is sampled this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_fsm
  import alu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_cmd_valid,
  input  logic i_rsp_ready,
  output logic o_cmd_ready,
  output logic o_rsp_valid,
  output logic o_accept,
  output logic o_exec
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_accept    = 1'b0;
    o_exec      = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          o_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        o_exec = 1'b1;
        w_next = WB;
      end
      WB: begin
        // Response is held here; no new command overlaps it.
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_sequencer
//  Description : Sequential wrapper around an external combinational 16-bit
//                ALU. Commands drive ALU operands A = acc[15:0], B = operand;
//                the ALU result is captured into a 32-bit accumulator and
//                returned with its error flags over a response handshake.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                bus (slave modport)        - command / response handshake
//                alu_a, alu_b, alu_opcode   - registered ALU operands
//                alu_result, alu_error      - ALU outputs
//                acc                        - live accumulator
//                op_count                   - completed operations (wraps)
//  Config      : ALU_ACC_STICKY_ERR_EN - rsp_error accumulates all error
//                flags since reset or the last clear (opcode 15) op.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  alu_acc_sequencer_if.slave  bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_opcode,
  input  logic [RES_W-1:0]    alu_result,
  input  logic [1:0]          alu_error,
  output logic [RES_W-1:0]    acc,
  output logic [CNT_W-1:0]    op_count
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_cmd_ready;
  logic              w_rsp_valid;
  logic              w_accept;
  logic              w_exec;

  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_op;
  logic              r_load;
  logic [RES_W-1:0]  r_acc;
  logic [RES_W-1:0]  r_rsp_result;
  logic [1:0]        r_rsp_error;
  logic [CNT_W-1:0]  r_op_count;

  logic [RES_W-1:0]  w_acc_next;
  logic [1:0]        w_op_err;
  logic [1:0]        w_err_next;

  alu_acc_fsm u_fsm (
    .clk         (clk),
    .reset       (reset),
    .i_cmd_valid (bus.cmd_valid),
    .i_rsp_ready (bus.rsp_ready),
    .o_cmd_ready (w_cmd_ready),
    .o_rsp_valid (w_rsp_valid),
    .o_accept    (w_accept),
    .o_exec      (w_exec)
  );

  // A load bypasses the ALU entirely; a divide-by-zero leaves acc untouched,
  // while an overflowing add/sub still commits the ALU result.
  always_comb begin
    w_op_err   = r_load ? 2'b00 : alu_error;
    w_acc_next = alu_result;
    if (r_load)
      w_acc_next = {{(RES_W-DATA_W){1'b0}}, r_alu_b};
    else if (alu_error[ERR_DIVZ])
      w_acc_next = r_acc;
  end

`ifdef ALU_ACC_STICKY_ERR_EN
  logic [1:0] r_sticky;
  logic [1:0] w_sticky_next;

  always_comb begin
    w_sticky_next = r_sticky | w_op_err;
    if (!r_load && (r_alu_op == OP_CLR))
      w_sticky_next = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset)       r_sticky <= 2'b00;
    else if (w_exec) r_sticky <= w_sticky_next;
  end

  assign w_err_next = w_sticky_next;
`else
  assign w_err_next = w_op_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= 4'd0;
      r_load       <= 1'b0;
      r_acc        <= '0;
      r_rsp_result <= '0;
      r_rsp_error  <= 2'b00;
      r_op_count   <= '0;
    end else begin
      // Command fields are captured only on the handshake edge.
      if (w_accept) begin
        r_alu_a  <= r_acc[DATA_W-1:0];
        r_alu_b  <= bus.cmd_operand;
        r_alu_op <= bus.cmd_op;
        r_load   <= bus.cmd_load;
      end
      if (w_exec) begin
        r_acc        <= w_acc_next;
        r_rsp_result <= w_acc_next;
        r_rsp_error  <= w_err_next;
        r_op_count   <= r_op_count + c_cnt_one;
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_error  = r_rsp_error;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_opcode     = r_alu_op;
  assign acc            = r_acc;
  assign op_count       = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_acc_sequencer
//  Description : Self-checking bench for alu_acc_sequencer with a behavioural
//                stand-in for the external ALU. A second instance with a
//                4-bit operation counter runs in lockstep to exercise wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_acc_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_acc_sequencer_if #(.DATA_W(16), .RES_W(32)) u_if ();
  alu_acc_sequencer_if #(.DATA_W(16), .RES_W(32)) u_if_w ();

  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic [31:0] acc;
  logic [15:0] op_count;

  logic [15:0] w_alu_a, w_alu_b;
  logic [3:0]  w_alu_opcode;
  logic [31:0] w_acc;
  logic [3:0]  w_op_count;

  alu_acc_sequencer #(.DATA_W(16), .RES_W(32), .CNT_W(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (u_if.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .acc        (acc),
    .op_count   (op_count)
  );

  // Same command stream, ALU tied off; only its counter is observed.
  assign u_if_w.cmd_valid   = u_if.cmd_valid;
  assign u_if_w.cmd_op      = u_if.cmd_op;
  assign u_if_w.cmd_load    = u_if.cmd_load;
  assign u_if_w.cmd_operand = u_if.cmd_operand;
  assign u_if_w.rsp_ready   = u_if.rsp_ready;

  alu_acc_sequencer #(.DATA_W(16), .RES_W(32), .CNT_W(4)) u_dut_w (
    .clk        (clk),
    .reset      (reset),
    .bus        (u_if_w.slave),
    .alu_a      (w_alu_a),
    .alu_b      (w_alu_b),
    .alu_opcode (w_alu_opcode),
    .alu_result (32'd0),
    .alu_error  (2'b00),
    .acc        (w_acc),
    .op_count   (w_op_count)
  );

  // Behavioural ALU: returns {error, result}
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    int unsigned ua, ub;
    logic [31:0] r;
    logic [1:0]  e;
    ua = a; ub = b; r = 32'd0; e = 2'b00;
    case (op)
      4'd0:  begin r = ua + ub; e[0] = ((ua + ub) > 65535); end
      4'd1:  begin r = ua - ub; e[0] = (ub > ua); end
      4'd2:  r = ua * ub;
      4'd3:  if (ub == 0) e = 2'b10; else r = ua / ub;
      4'd4:  if (ub == 0) e = 2'b10; else r = ua % ub;
      4'd5:  r = ua ^ ub;
      4'd6:  r = ~(ua ^ ub) & 32'hFFFF;
      4'd7:  r = ua | ub;
      4'd8:  r = ~(ua | ub) & 32'hFFFF;
      4'd9:  r = ua & ub;
      4'd10: r = ~(ua & ub) & 32'hFFFF;
      4'd11: r = ~ua & 32'hFFFF;
      4'd14: r = 32'hFFFF_FFFF;
      default: r = 32'd0;
    endcase
    return {e, r};
  endfunction

  always_comb {alu_error, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Reference model: calculator semantics in plain arithmetic
  logic [31:0] m_acc;
  int unsigned m_count;
  logic [1:0]  m_sticky;

  task automatic model_reset();
    m_acc = 32'd0; m_count = 0; m_sticky = 2'b00;
  endtask

  task automatic model_op(input bit ld, input logic [3:0] op, input logic [15:0] opd,
                          output logic [31:0] er, output logic [1:0] ee);
    logic [33:0] o;
    logic [1:0]  e_this;
    e_this = 2'b00;
    if (ld) m_acc = {16'd0, opd};
    else begin
      o = alu_fn(op, m_acc[15:0], opd);
      e_this = o[33:32];
      if (!e_this[1]) m_acc = o[31:0];
    end
    er = m_acc;
`ifdef ALU_ACC_STICKY_ERR_EN
    if (!ld && op == 4'd15) m_sticky = 2'b00;
    else m_sticky = m_sticky | e_this;
    ee = m_sticky;
`else
    ee = e_this;
`endif
    m_count++;
  endtask

  // Issue one command; optionally hold rsp_ready low for 'stall' cycles in WB
  // while a competing command is presented.
  task automatic send(input bit ld, input logic [3:0] op, input logic [15:0] opd,
                      input int stall, output logic [31:0] res, output logic [1:0] err,
                      output int lat);
    int n;
    @(negedge clk);
    u_if.rsp_ready   = (stall == 0);
    u_if.cmd_valid   = 1'b1;
    u_if.cmd_load    = ld;
    u_if.cmd_op      = op;
    u_if.cmd_operand = opd;
    n = 0;
    while (!u_if.cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!u_if.cmd_ready) timeout_fail("cmd_accept");
    @(negedge clk);
    u_if.cmd_valid   = 1'b0;
    u_if.cmd_load    = 1'($urandom);
    u_if.cmd_op      = 4'($urandom);
    u_if.cmd_operand = 16'($urandom);
    lat = 1;
    while (!u_if.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!u_if.rsp_valid) timeout_fail("rsp_valid");
    res = u_if.rsp_result;
    err = u_if.rsp_error;
    for (int i = 0; i < stall; i++) begin
      if (i == 0) u_if.cmd_valid = 1'b1;
      @(negedge clk);
      chk("stall_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
      chk("stall_rsp_result", u_if.rsp_result, res);
      chk("stall_rsp_error", 32'(u_if.rsp_error), 32'(err));
      chk("stall_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
    end
    if (stall > 0) begin
      u_if.cmd_valid = 1'b0;
      u_if.rsp_ready = 1'b1;
    end
  endtask

  task automatic run_op(input bit ld, input logic [3:0] op, input logic [15:0] opd,
                        input int stall);
    logic [31:0] res, er;
    logic [1:0]  err, ee;
    int lat;
    send(ld, op, opd, stall, res, err, lat);
    model_op(ld, op, opd, er, ee);
    chk("rsp_result", res, er);
    chk("rsp_error", 32'(err), 32'(ee));
    chk("acc", acc, m_acc);
    chk("latency", 32'(lat), 32'd2);
    chk("op_count", 32'(op_count), m_count & 32'hFFFF);
    chk("op_count_wrap4", 32'(w_op_count), m_count % 16);
  endtask

  typedef struct {
    bit          ld;
    logic [3:0]  op;
    logic [15:0] opd;
    logic [31:0] res;
    logic [1:0]  err;
    logic [1:0]  err_st;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [1:0]  err, exp_err;
    int lat;

    tbl[0]  = '{1'b1, 4'd0,  16'd15,     32'd15,         2'b00, 2'b00};
    tbl[1]  = '{1'b0, 4'd0,  16'd126,    32'd141,        2'b00, 2'b00};
    tbl[2]  = '{1'b1, 4'd0,  16'd15,     32'd15,         2'b00, 2'b00};
    tbl[3]  = '{1'b0, 4'd2,  16'd126,    32'd1890,       2'b00, 2'b00};
    tbl[4]  = '{1'b1, 4'd0,  16'd100,    32'd100,        2'b00, 2'b00};
    tbl[5]  = '{1'b0, 4'd3,  16'd0,      32'd100,        2'b10, 2'b10};
    tbl[6]  = '{1'b0, 4'd3,  16'd7,      32'd14,         2'b00, 2'b10};
    tbl[7]  = '{1'b0, 4'd4,  16'd0,      32'd14,         2'b10, 2'b10};
    tbl[8]  = '{1'b0, 4'd15, 16'd0,      32'd0,          2'b00, 2'b00};
    tbl[9]  = '{1'b0, 4'd0,  16'd1,      32'd1,          2'b00, 2'b00};
    tbl[10] = '{1'b1, 4'd0,  16'hFFFF,   32'h0000_FFFF,  2'b00, 2'b00};
    tbl[11] = '{1'b0, 4'd0,  16'd1,      32'h0001_0000,  2'b01, 2'b01};
    tbl[12] = '{1'b0, 4'd11, 16'd0,      32'h0000_FFFF,  2'b00, 2'b01};
    tbl[13] = '{1'b0, 4'd14, 16'd0,      32'hFFFF_FFFF,  2'b00, 2'b01};
    tbl[14] = '{1'b0, 4'd1,  16'd1,      32'h0000_FFFE,  2'b00, 2'b01};
    tbl[15] = '{1'b0, 4'd5,  16'h00FF,   32'h0000_FF01,  2'b00, 2'b01};

    reset = 1'b1;
    u_if.cmd_valid = 1'b0; u_if.cmd_load = 1'b0; u_if.cmd_op = 4'd0;
    u_if.cmd_operand = 16'd0; u_if.rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("reset_acc", acc, 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);
    chk("reset_rsp_result", u_if.rsp_result, 32'd0);
    chk("reset_rsp_error", 32'(u_if.rsp_error), 32'd0);
    chk("reset_alu_ops", {alu_a, alu_b}, 32'd0);
    chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].ld, tbl[i].op, tbl[i].opd, 0, res, err, lat);
      model_op(tbl[i].ld, tbl[i].op, tbl[i].opd, res[31:0] == res ? m_acc : m_acc, exp_err);
`ifdef ALU_ACC_STICKY_ERR_EN
      exp_err = tbl[i].err_st;
`else
      exp_err = tbl[i].err;
`endif
      chk($sformatf("tbl%0d_result", i), res, tbl[i].res);
      chk($sformatf("tbl%0d_error", i), 32'(err), 32'(exp_err));
      chk($sformatf("tbl%0d_acc", i), acc, tbl[i].res);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("tbl%0d_op_count", i), 32'(op_count), 32'(i + 1));
    end

    // Backpressure: 3 stalled cycles in WB with a competing command
    run_op(1'b0, 4'd0, 16'd5, 3);
    run_op(1'b0, 4'd2, 16'd3, 0);

    // Reset while an operation is in EXEC
    @(negedge clk);
    u_if.cmd_valid = 1'b1; u_if.cmd_load = 1'b1; u_if.cmd_operand = 16'd1234;
    lat = 0;
    while (!u_if.cmd_ready && lat < 20) begin @(negedge clk); lat++; end
    if (!u_if.cmd_ready) timeout_fail("exec_reset_accept");
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    chk("exec_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("exec_reset_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("exec_reset_acc", acc, 32'd0);
    chk("exec_reset_op_count", 32'(op_count), 32'd0);
    chk("exec_reset_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exec_reset_no_rsp", 32'(u_if.rsp_valid), 32'd0);
    end

    // Sticky / clear sequence from a fresh state
    run_op(1'b1, 4'd0, 16'd100, 0);
    run_op(1'b0, 4'd3, 16'd0, 0);
    run_op(1'b0, 4'd0, 16'd1, 0);
    run_op(1'b0, 4'd15, 16'd0, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      run_op(($urandom % 4) == 0, 4'($urandom), (($urandom % 8) == 0) ? 16'd0 : 16'($urandom),
             (($urandom % 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
